// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory-stall control signals between the pipeline datapath and pipeline_ctrl.
// The slave modport is the control block; the master is the datapath (or a bench) driving it.
interface pipeline_ctrl_if;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RDaddr_i;
  logic [4:0]  IFID_RS1_i;
  logic [4:0]  IFID_RS2_i;
  logic        Branch_i;
  logic        MemReq_i;
  logic        MemHit_i;
  logic        MemAck_i;
  logic        Stall_o;
  logic        Flush_o;
  logic        MemStall_o;
  logic        PCWrite_o;
  logic        NoOp_o;
  logic [15:0] StallCnt_o;
  logic [15:0] MissCnt_o;
  logic        Timeout_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1_i, IFID_RS2_i,
    output Branch_i, MemReq_i, MemHit_i, MemAck_i,
    input  Stall_o, Flush_o, MemStall_o, PCWrite_o, NoOp_o,
    input  StallCnt_o, MissCnt_o, Timeout_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1_i, IFID_RS2_i,
    input  Branch_i, MemReq_i, MemHit_i, MemAck_i,
    output Stall_o, Flush_o, MemStall_o, PCWrite_o, NoOp_o,
    output StallCnt_o, MissCnt_o, Timeout_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-cache miss FSM with
// saturating stall/miss statistics and a sticky miss watchdog.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic {StRun, StMiss} state_e;

  state_e      state_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] miss_cnt_q;
  logic [7:0]  wait_q;
  logic        timeout_q;

  logic       miss_req;
  logic       mem_stall;
  logic       hazard;
  logic       stall;
  logic [7:0] wait_inc;

  always_comb begin
    miss_req  = bus.MemReq_i & ~bus.MemHit_i;
    mem_stall = (state_q == StMiss) | miss_req;
    hazard    = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
                ((bus.IDEX_RDaddr_i == bus.IFID_RS1_i) ||
                 (bus.IDEX_RDaddr_i == bus.IFID_RS2_i));
    // A pending memory stall freezes everything, so the load-use stall yields to it.
    stall     = hazard & ~mem_stall;
    wait_inc  = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
  end

  assign bus.MemStall_o = mem_stall;
  assign bus.Stall_o    = stall;
  assign bus.NoOp_o     = stall;
  assign bus.Flush_o    = bus.Branch_i & ~stall & ~mem_stall;
  assign bus.PCWrite_o  = ~(stall | mem_stall);
  assign bus.StallCnt_o = stall_cnt_q;
  assign bus.MissCnt_o  = miss_cnt_q;
  assign bus.Timeout_o  = timeout_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StRun;
      stall_cnt_q <= 16'd0;
      miss_cnt_q  <= 16'd0;
      wait_q      <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      unique case (state_q)
        StRun: begin
          if (miss_req) begin
            state_q <= StMiss;
            wait_q  <= 8'd0;
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_q <= miss_cnt_q + 16'd1;
            end
          end
        end
        StMiss: begin
          wait_q <= wait_inc;
          // Watchdog only flags; the miss still waits for its acknowledge.
          if ({24'd0, wait_inc} >= TIMEOUT) begin
            timeout_q <= 1'b1;
          end
          if (bus.MemAck_i) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: each vector pushes its hand-computed expected
// outputs into a scoreboard queue that a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.TIMEOUT(255)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic        stall;
    logic        noop;
    logic        flush;
    logic        mstall;
    logic        pcw;
    logic [15:0] scnt;
    logic [15:0] mcnt;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;

  task automatic check(input string name, input int id, input logic [15:0] act,
                       input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, req);
    end
  endtask

  // Apply one cycle of stimulus just after the rising edge and queue its expected response.
  task automatic vec(input logic rst, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                     input logic req, input logic hit, input logic ack,
                     input logic e_stall, input logic e_flush, input logic e_mst,
                     input logic e_pcw, input int e_scnt, input int e_mcnt, input logic e_to);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i              = rst;
    bus.IDEX_MemRead_i = mr;
    bus.IDEX_RDaddr_i  = rd;
    bus.IFID_RS1_i     = rs1;
    bus.IFID_RS2_i     = rs2;
    bus.Branch_i       = br;
    bus.MemReq_i       = req;
    bus.MemHit_i       = hit;
    bus.MemAck_i       = ack;
    e.id     = vec_id;
    e.stall  = e_stall;
    e.noop   = e_stall;
    e.flush  = e_flush;
    e.mstall = e_mst;
    e.pcw    = e_pcw;
    e.scnt   = 16'(e_scnt);
    e.mcnt   = 16'(e_mcnt);
    e.tmo    = e_to;
    sb.push_back(e);
    vec_id++;
  endtask

  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("Stall_o",    e.id, {15'd0, bus.Stall_o},    {15'd0, e.stall});
      check("NoOp_o",     e.id, {15'd0, bus.NoOp_o},     {15'd0, e.noop});
      check("Flush_o",    e.id, {15'd0, bus.Flush_o},    {15'd0, e.flush});
      check("MemStall_o", e.id, {15'd0, bus.MemStall_o}, {15'd0, e.mstall});
      check("PCWrite_o",  e.id, {15'd0, bus.PCWrite_o},  {15'd0, e.pcw});
      check("StallCnt_o", e.id, bus.StallCnt_o,          e.scnt);
      check("MissCnt_o",  e.id, bus.MissCnt_o,           e.mcnt);
      check("Timeout_o",  e.id, {15'd0, bus.Timeout_o},  {15'd0, e.tmo});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.IDEX_MemRead_i = 1'b0;
    bus.IDEX_RDaddr_i  = 5'd0;
    bus.IFID_RS1_i     = 5'd0;
    bus.IFID_RS2_i     = 5'd0;
    bus.Branch_i       = 1'b0;
    bus.MemReq_i       = 1'b0;
    bus.MemHit_i       = 1'b0;
    bus.MemAck_i       = 1'b0;

    //  rst mr rd  rs1 rs2 br req hit ack | stall flush mst pcw scnt mcnt to
    // Reset state; combinational outputs still follow a miss request while held in reset.
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    // Load-use on RS1, then on RS2.
    vec(1, 1, 5, 5, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 0);
    vec(1, 1, 7, 3, 7, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0);
    // x0 never hazards; no hazard without a load.
    vec(1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2, 0, 0);
    vec(1, 0, 5, 5, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2, 0, 0);
    // Branch alone flushes; branch under load-use stall waits and is taken next cycle.
    vec(1, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 2, 0, 0);
    vec(1, 1, 5, 5, 0, 1, 0, 0, 0,   1, 0, 0, 0, 2, 0, 0);
    vec(1, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 3, 0, 0);
    // Cache hit and a stray ack in RUN change nothing.
    vec(1, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 1, 3, 0, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 3, 0, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 0, 0);

    // Miss at cycle 0 with hazard and branch; MemStall dominates.
    vec(1, 1, 5, 5, 0, 1, 1, 0, 0,   0, 0, 1, 0, 3, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      vec(1, 1, 5, 5, 0, 1, 1, 0, 0, 0, 0, 1, 0, 3, 1, 0);
    end
    vec(1, 1, 5, 5, 0, 0, 0, 0, 1,   0, 0, 1, 0, 3, 1, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 1, 0);
    // Second miss right after the single gap cycle.
    vec(1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 3, 1, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 3, 2, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 3, 2, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 2, 0);

    // Unacknowledged miss: flag appears once 255 MISS edges have elapsed.
    vec(1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 3, 2, 0);
    for (int i = 1; i <= 300; i++) begin
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 3, (i >= 256));
    end
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 3, 3, 1);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 3, 1);

    // Reset in the middle of a miss clears everything without a clock edge.
    vec(1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 3, 3, 1);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 3, 4, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);

    @(negedge clk_i);
    @(negedge clk_i);
    check("scoreboard_drained", vec_id, 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
